// File: rtl/dma_pkg.sv
// Shared types and constants for the sprite OAM DMA engine.
// Optional feature macro (used by oam_dma): OAM_DMA_ALIGN_EN.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  // Number of READ/WRITE pairs in one transfer (one full 256-byte page)
  localparam int DMA_PAIRS = 256;

  // Default CPU write address that starts a transfer
  localparam logic [15:0] DEF_TRIGGER_ADDR = 16'h4014;

  // Default destination of every DMA write (PPU OAM data port)
  localparam logic [15:0] DEF_OAM_PORT = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops CPU writes to the trigger address, stalls the
// core, then copies page {V,$00..$FF} to the PPU OAM port one byte at a time.
// Optional feature macro: OAM_DMA_ALIGN_EN inserts one dummy alignment cycle
// when the transfer would otherwise start on an odd clock (2A03 513/514 timing).
module oam_dma
  import dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DEF_TRIGGER_ADDR,
  parameter logic [15:0] OAM_PORT     = DEF_OAM_PORT
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic [15:0] I_cpu_addr,
  input  logic [7:0]  I_cpu_wr_data,
  input  logic        I_cpu_rdwr,
  input  logic [7:0]  I_rd_data,
  output logic        O_cpu_ready,
  output logic [15:0] O_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_rdwr,
  output logic        O_busy
);

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_IDX = 8'(DMA_PAIRS - 1);

  dma_state_t  state_q;
  dma_state_t  state_d;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  latch_q;
  logic        parity_q;
  logic        trigger_hit;
  logic        need_align;

  assign trigger_hit = (I_cpu_addr == TRIGGER_ADDR) && !I_cpu_rdwr;
  assign need_align  = ALIGN_EN && parity_q;

  // State register plus the free-running clock parity flop
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
    end
  end

  // Page/index/data registers: capture page on trigger, byte on READ, advance on WRITE
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      latch_q <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger_hit) begin
            page_q <= I_cpu_wr_data;
            idx_q  <= 8'h00;
          end
        end
        READ:    latch_q <= I_rd_data;
        WRITE:   idx_q   <= idx_q + 8'd1;
        default: ;
      endcase
    end
  end

  // Next-state logic; HALT waits for the core to reach a read cycle before taking the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (trigger_hit) state_d = HALT;
      HALT:    if (I_cpu_rdwr) state_d = need_align ? ALIGN : READ;
      ALIGN:   state_d = READ;
      READ:    state_d = WRITE;
      WRITE:   state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      default: state_d = IDLE;
    endcase
  end

  assign O_cpu_ready = (state_q == IDLE);
  assign O_busy      = (state_q == ALIGN) || (state_q == READ) || (state_q == WRITE);

  // Bus mux: DMA drives the bus only while it owns it, otherwise pure CPU passthrough
  always_comb begin
    O_addr    = I_cpu_addr;
    O_wr_data = I_cpu_wr_data;
    O_rdwr    = I_cpu_rdwr;
    if (O_busy) begin
      O_wr_data = latch_q;
      if (state_q == WRITE) begin
        O_addr = OAM_PORT;
        O_rdwr = 1'b0;
      end else begin
        O_addr = {page_q, idx_q};
        O_rdwr = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: per-cycle comparison against a schedule
// model of the transfer, plus hand-computed literal checks per scenario.
// Honours OAM_DMA_ALIGN_EN the same way the design does.
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;
  localparam int          XFER = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr    = 16'h8000;
  logic [7:0]  cpu_wr_data = 8'h00;
  logic        cpu_rdwr    = 1'b1;
  logic [7:0]  rd_data;
  logic        cpu_ready;
  logic [15:0] o_addr;
  logic [7:0]  o_wr_data;
  logic        o_rdwr;
  logic        busy;

  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  // Transfer-schedule model
  int         cyc       = 0;
  bit         m_halting = 1'b0;
  bit         m_xfer    = 1'b0;
  int         m_start   = 0;
  int         m_busy_from = 0;
  logic [7:0] m_page    = 8'h00;

  // Observations of DUT behaviour
  int          wr_total    = 0;
  int          stall_total = 0;
  int          halt_total  = 0;
  logic [15:0] first_busy_addr = 16'h0000;
  logic [15:0] last_read_addr  = 16'h0000;
  bit          prev_busy = 1'b0;
  logic [7:0]  wr_log [$];

  oam_dma dut (
    .I_clock       (clk),
    .I_reset       (rst_n),
    .I_cpu_addr    (cpu_addr),
    .I_cpu_wr_data (cpu_wr_data),
    .I_cpu_rdwr    (cpu_rdwr),
    .I_rd_data     (rd_data),
    .O_cpu_ready   (cpu_ready),
    .O_addr        (o_addr),
    .O_wr_data     (o_wr_data),
    .O_rdwr        (o_rdwr),
    .O_busy        (busy)
  );

  always #5 clk = ~clk;

  // Bus memory model: read data follows the bus address
  assign rd_data = mem[o_addr];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_idle(input int c);
    return !m_halting && !(m_xfer && c < m_start + XFER);
  endfunction

  function automatic bit m_busy(input int c);
    return m_xfer && c >= m_busy_from && c < m_start + XFER;
  endfunction

  // Model update: trigger while idle starts a halt; the first read cycle in halt schedules the copy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_halting <= 1'b0;
      m_xfer    <= 1'b0;
      cyc       <= 0;
    end else begin
      if (m_idle(cyc) && cpu_addr == TRIG && !cpu_rdwr) begin
        m_halting <= 1'b1;
        m_page    <= cpu_wr_data;
      end else if (m_halting && cpu_rdwr) begin
        m_halting   <= 1'b0;
        m_xfer      <= 1'b1;
        m_busy_from <= cyc + 1;
        m_start     <= cyc + 1 + ((ALIGN_EN && cyc[0]) ? 1 : 0);
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle compare against the model, plus bookkeeping of what the DUT did
  always @(negedge clk) begin
    int         off;
    logic [7:0] pair;
    check("cpu_ready", cpu_ready, m_idle(cyc));
    check("busy", busy, m_busy(cyc));
    if (m_busy(cyc)) begin
      off = cyc - m_start;
      if (off < 0) begin
        check("align_addr", o_addr, {m_page, 8'h00});
        check("align_rdwr", o_rdwr, 1);
      end else begin
        pair = 8'(off / 2);
        if (off % 2 == 0) begin
          check("rd_addr", o_addr, {m_page, pair});
          check("rd_rdwr", o_rdwr, 1);
        end else begin
          check("wr_addr", o_addr, OAM);
          check("wr_rdwr", o_rdwr, 0);
          check("wr_data", o_wr_data, mem[{m_page, pair}]);
        end
      end
    end else begin
      check("pass_addr", o_addr, cpu_addr);
      check("pass_data", o_wr_data, cpu_wr_data);
      check("pass_rdwr", o_rdwr, cpu_rdwr);
    end
    if (!cpu_ready) stall_total++;
    if (!cpu_ready && !busy) halt_total++;
    if (busy && !prev_busy) first_busy_addr = o_addr;
    if (busy && o_rdwr) last_read_addr = o_addr;
    if (busy && !o_rdwr && o_addr == OAM) begin
      wr_log.push_back(o_wr_data);
      wr_total++;
    end
    prev_busy = busy;
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic rd);
    @(posedge clk);
    #1;
    cpu_addr    = a;
    cpu_wr_data = d;
    cpu_rdwr    = rd;
  endtask

  // Wait (bounded) until the core is released; a timeout shows up as a failed ready check
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (!(cpu_ready && !busy) && n < 800) begin
      @(negedge clk);
      n++;
    end
    check({name, "_released"}, cpu_ready, 1);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    check(name, act, exp);
  endtask

  initial begin
    int base;
    int base2;
    int bs;
    int bh;
    int n;
    logic [15:0] ra;

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a) + 8'(a >> 8);
    for (int i = 0; i < 256; i++) begin
      mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
      mem[16'hFF00 + i] = 8'(i) ^ 8'hC3;
    end

    rst_n = 1'b0;
    #2;
    checkOutput("reset_ready", cpu_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_addr", o_addr, 16'h8000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Test 1: full page copy from $0200, triggered on an even clock
    $display("[TB] test 1: page $02 copy");
    base = wr_total;
    bs   = stall_total;
    @(posedge clk);
    #1;
    if (cyc[0]) begin
      @(posedge clk);
      #1;
    end
    cpu_addr = TRIG; cpu_wr_data = 8'h02; cpu_rdwr = 1'b0;
    applyStimulus(16'h8000, 8'h00, 1'b1);
    waitIdle("t1");
    checkOutput("t1_writes", wr_total - base, 256);
    checkOutput("t1_data10", wr_log[base + 16], 8'h4A);
    checkOutput("t1_dataFF", wr_log[base + 255], 8'hA5);
    checkOutput("t1_stall", stall_total - bs, ALIGN_EN ? 514 : 513);

    // Test 2/3: core keeps writing during halt; retrigger attempts while busy are ignored
    $display("[TB] test 2/3: extended halt and ignored retrigger");
    base = wr_total;
    bh   = halt_total;
    applyStimulus(TRIG, 8'h02, 1'b0);
    applyStimulus(TRIG, 8'h02, 1'b0);
    applyStimulus(TRIG, 8'h02, 1'b0);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(TRIG, 8'h05, 1'b0);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    waitIdle("t2");
    checkOutput("t2_halt_cycles", halt_total - bh, 3);
    checkOutput("t2_first_read", first_busy_addr, 16'h0200);
    checkOutput("t3_writes", wr_total - base, 256);
    checkOutput("t3_data01", wr_log[base + 1], 8'h5B);

    // Test 5: top page $FF
    $display("[TB] test 5: page $FF");
    base = wr_total;
    applyStimulus(TRIG, 8'hFF, 1'b0);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    waitIdle("t5");
    checkOutput("t5_writes", wr_total - base, 256);
    checkOutput("t5_last_read", last_read_addr, 16'hFFFF);
    checkOutput("t5_data00", wr_log[base], 8'hC3);
    checkOutput("t5_dataFF", wr_log[base + 255], 8'h3C);
    checkOutput("t5_busy_after", busy, 0);

    // Test 4: reset in the middle of the transfer, then a fresh transfer
    $display("[TB] test 4: reset mid-transfer");
    base = wr_total;
    applyStimulus(TRIG, 8'h02, 1'b0);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    n = 0;
    while (wr_total - base < 64 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t4_reached_40", wr_total - base, 64);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_ready", cpu_ready, 1);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_addr", o_addr, 16'h8000);
    checkOutput("t4_rdwr", o_rdwr, 1);
    checkOutput("t4_data", o_wr_data, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("t4_no_more_writes", wr_total - base, 64);
    base2 = wr_total;
    applyStimulus(TRIG, 8'h02, 1'b0);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    waitIdle("t4b");
    checkOutput("t4_restart_writes", wr_total - base2, 256);
    checkOutput("t4_restart_first", first_busy_addr, 16'h0200);
    checkOutput("t4_restart_data0", wr_log[base2], 8'h5A);

    // Test 6: random idle traffic never touching the trigger with a write
    $display("[TB] test 6: idle passthrough");
    base = wr_total;
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      if (ra == TRIG) ra = 16'h4015;
      applyStimulus(ra, 8'($urandom), 1'($urandom));
    end
    applyStimulus(16'h8000, 8'h00, 1'b1);
    checkOutput("t6_ready", cpu_ready, 1);
    checkOutput("t6_no_writes", wr_total - base, 0);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
